ccd_readout_sync: RTL and testbench

CCD_READOUT_SYNC -- requirements
Module: ccd_readout_sync

---
 rtl/ccd_readout_sync.sv | 218 +++++++++++++++++++++
 tb/tb_ccd_readout_sync.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_readout_sync.sv
// CCD readout sequencer: synchronizes the clock phases and issues CDS reference/signal
// strobes to the ADC, tracking the pixel and line position within a frame.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | block disabled, counters cleared
// S_WAIT_P  | waiting for a phi_p rise (start of a line)
// S_WAIT_R  | waiting for a phi_r fall (start of a pixel)
// S_REF_CNT | counting REF_DELAY cycles to the sample_ref strobe
// S_WAIT_L2 | waiting for a phi_l2 rise (charge dumped onto the sense node)
// S_SIG_CNT | counting SIG_DELAY cycles to the sample_sig strobe
module ccd_readout_sync #(
    parameter int PIX_PER_LINE    = 16,
    parameter int LINES_PER_FRAME = 16,
    parameter int REF_DELAY       = 2,
    parameter int SIG_DELAY       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       phi_p,
    input  logic       phi_l1,
    input  logic       phi_l2,
    input  logic       phi_r,
    output logic       sample_ref,
    output logic       sample_sig,
    output logic       pix_valid,
    output logic [9:0] pix_idx,
    output logic [9:0] line_idx,
    output logic       line_start,
    output logic       frame_done,
    output logic       err_short_line
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_P,
        S_WAIT_R,
        S_REF_CNT,
        S_WAIT_L2,
        S_SIG_CNT
    } state_t;

    localparam logic [9:0] PIX_LAST  = 10'(PIX_PER_LINE - 1);
    localparam logic [9:0] LINE_LAST = 10'(LINES_PER_FRAME - 1);
    localparam logic [3:0] REF_LD    = 4'(REF_DELAY - 1);
    localparam logic [3:0] SIG_LD    = 4'(SIG_DELAY - 1);

    // bit order {phi_p, phi_l1, phi_l2, phi_r}
    logic [3:0] r_sync1, r_sync2, r_hist;

    state_t     r_state, w_state;
    logic [3:0] r_cnt, w_cnt;
    logic [9:0] r_pix, w_pix;
    logic [9:0] r_line, w_line;
    logic       r_adv, w_adv;
    logic       r_sref, w_sref;
    logic       r_ssig, w_ssig;
    logic       r_lstart, w_lstart;
    logic       r_fdone, w_fdone;
    logic       r_err, w_err;

    logic w_p_rise, w_l1_rise, w_l2_rise, w_r_fall;

    assign w_p_rise  = r_sync2[3] & ~r_hist[3];
    assign w_l1_rise = r_sync2[2] & ~r_hist[2];
    assign w_l2_rise = r_sync2[1] & ~r_hist[1];
    assign w_r_fall  = ~r_sync2[0] & r_hist[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= {phi_p, phi_l1, phi_l2, phi_r};
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_pix    <= '0;
            r_line   <= '0;
            r_adv    <= 1'b0;
            r_sref   <= 1'b0;
            r_ssig   <= 1'b0;
            r_lstart <= 1'b0;
            r_fdone  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_pix    <= w_pix;
            r_line   <= w_line;
            r_adv    <= w_adv;
            r_sref   <= w_sref;
            r_ssig   <= w_ssig;
            r_lstart <= w_lstart;
            r_fdone  <= w_fdone;
            r_err    <= w_err;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_pix    = r_pix;
        w_line   = r_line;
        w_adv    = 1'b0;
        w_sref   = 1'b0;
        w_ssig   = 1'b0;
        w_lstart = 1'b0;
        w_fdone  = 1'b0;
        w_err    = r_err;

        // Indices hold through the sample_sig cycle and advance on the edge after it.
        if (r_adv) begin
            if (r_pix != PIX_LAST) begin
                w_pix = r_pix + 10'd1;
            end else if (r_line != LINE_LAST) begin
                w_line = r_line + 10'd1;
            end else begin
                w_line = '0;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (enable) w_state = S_WAIT_P;
            end
            S_WAIT_P: begin
                if (w_p_rise) begin
                    w_state  = S_WAIT_R;
                    w_lstart = 1'b1;
                    w_pix    = '0;
                end
            end
            S_WAIT_R, S_REF_CNT, S_WAIT_L2, S_SIG_CNT: begin
                if (w_p_rise) begin
                    // short line: abort the pixel and start the next line
                    w_state  = S_WAIT_R;
                    w_lstart = 1'b1;
                    w_err    = 1'b1;
                    w_pix    = '0;
                    w_cnt    = '0;
                    w_line   = (w_line == LINE_LAST) ? 10'd0 : w_line + 10'd1;
                end else begin
                    case (r_state)
                        S_WAIT_R: begin
                            if (w_r_fall) begin
                                w_state = S_REF_CNT;
                                w_cnt   = REF_LD;
                            end
                        end
                        S_REF_CNT: begin
                            if (r_cnt == 4'd0) begin
                                w_sref  = 1'b1;
                                w_state = S_WAIT_L2;
                            end else begin
                                w_cnt = r_cnt - 4'd1;
                            end
                        end
                        S_WAIT_L2: begin
                            if (w_l2_rise) begin
                                w_state = S_SIG_CNT;
                                w_cnt   = SIG_LD;
                            end else if (w_l1_rise) begin
                                w_state = S_WAIT_L2;
                            end
                        end
                        default: begin
                            if (r_cnt == 4'd0) begin
                                w_ssig = 1'b1;
                                w_adv  = 1'b1;
                                if (w_pix != PIX_LAST) begin
                                    w_state = S_WAIT_R;
                                end else begin
                                    w_state = S_WAIT_P;
                                    w_fdone = (w_line == LINE_LAST);
                                end
                            end else begin
                                w_cnt = r_cnt - 4'd1;
                            end
                        end
                    endcase
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (!enable) begin
            w_state  = S_IDLE;
            w_cnt    = '0;
            w_pix    = '0;
            w_line   = '0;
            w_adv    = 1'b0;
            w_sref   = 1'b0;
            w_ssig   = 1'b0;
            w_lstart = 1'b0;
            w_fdone  = 1'b0;
            w_err    = r_err;
        end
    end

    assign sample_ref     = r_sref;
    assign sample_sig     = r_ssig;
    assign pix_valid      = r_ssig;
    assign pix_idx        = r_pix;
    assign line_idx       = r_line;
    assign line_start     = r_lstart;
    assign frame_done     = r_fdone;
    assign err_short_line = r_err;

endmodule

// File: tb/tb_ccd_readout_sync.sv
// Directed bench for ccd_readout_sync: expected pixel samples are queued as phi_l2 is
// driven and checked against each sample_sig.
module tb_ccd_readout_sync;

    logic       clk = 1'b0;
    logic       rst, enable, phi_p, phi_l1, phi_l2, phi_r;
    logic       sample_ref, sample_sig, pix_valid, line_start, frame_done, err_short_line;
    logic [9:0] pix_idx, line_idx;

    typedef struct packed {
        logic [9:0] p;
        logic [9:0] l;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cnt_sref = 0, cnt_ssig = 0, cnt_ls = 0, cnt_fd = 0;
    int last_sref_cyc = -1, last_ssig_cyc = -1;
    int exp_sref = 0, exp_ssig = 0, exp_ls = 0, exp_fd = 0;
    int exp_ls_line = 0;

    ccd_readout_sync #(
        .PIX_PER_LINE(4), .LINES_PER_FRAME(2), .REF_DELAY(2), .SIG_DELAY(3)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .phi_p(phi_p), .phi_l1(phi_l1), .phi_l2(phi_l2), .phi_r(phi_r),
        .sample_ref(sample_ref), .sample_sig(sample_sig), .pix_valid(pix_valid),
        .pix_idx(pix_idx), .line_idx(line_idx), .line_start(line_start),
        .frame_done(frame_done), .err_short_line(err_short_line)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // outputs sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (sample_ref) begin
                cnt_sref++;
                last_sref_cyc = cyc;
            end
            if (sample_sig || pix_valid || frame_done) begin
                chk("pix_valid_with_sig", {31'd0, pix_valid}, {31'd0, sample_sig});
                if (sample_sig) begin
                    cnt_ssig++;
                    last_ssig_cyc = cyc;
                    if (frame_done) cnt_fd++;
                    chk("sig_expected", {31'd0, sb.size() > 0}, 32'd1);
                    if (sb.size() > 0) begin
                        m_e = sb.pop_front();
                        chk("sig_pix_idx", {22'd0, pix_idx}, {22'd0, m_e.p});
                        chk("sig_line_idx", {22'd0, line_idx}, {22'd0, m_e.l});
                        chk("sig_frame_done", {31'd0, frame_done}, {31'd0, m_e.fd});
                    end
                end else begin
                    chk("frame_done_alone", {31'd0, frame_done}, 32'd0);
                end
            end
            if (line_start) begin
                cnt_ls++;
                chk("ls_pix_idx", {22'd0, pix_idx}, 32'd0);
                chk("ls_line_idx", {22'd0, line_idx}, exp_ls_line);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic p_pulse();
        phi_p = 1'b1;
        wait_neg(2);
        phi_p = 1'b0;
        wait_neg(3);
        exp_ls++;
    endtask

    task automatic push_exp(input int p, input int l, input int fd);
        exp_t e;
        e.p  = 10'(p);
        e.l  = 10'(l);
        e.fd = fd[0];
        sb.push_back(e);
    endtask

    // one pixel of phase activity; expect=1 when the DUT should sample it
    task automatic do_pixel(input int expect_smp, input int p, input int l, input int fd);
        phi_r = 1'b1;
        wait_neg(2);
        phi_r = 1'b0;
        wait_neg(3);
        phi_l1 = 1'b1;
        wait_neg(2);
        if (expect_smp != 0) begin
            push_exp(p, l, fd);
            exp_sref++;
            exp_ssig++;
            if (fd != 0) exp_fd++;
        end
        phi_l2 = 1'b1;
        wait_neg(2);
        phi_l1 = 1'b0;
        phi_l2 = 1'b0;
        wait_neg(6);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk(tag, {9'd0, sample_ref, sample_sig, pix_valid, line_start, frame_done,
                  err_short_line, pix_idx, line_idx}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0;
        phi_p = 1'b0; phi_l1 = 1'b0; phi_l2 = 1'b0; phi_r = 1'b0;
        #1;
        chk_outputs_zero("reset_outputs_t0");
        wait_neg(3);
        chk_outputs_zero("reset_outputs_held");
        rst = 1'b0;
        wait_neg(1);
        enable = 1'b1;
        wait_neg(2);

        // line 0, pixel 0 with cycle-exact timing
        exp_ls_line = 0;
        p_pulse();
        phi_r = 1'b1;
        while (cyc < 99) @(negedge clk);
        phi_r = 1'b0;
        exp_sref++;
        while (cyc < 119) @(negedge clk);
        push_exp(0, 0, 0);
        exp_ssig++;
        phi_l2 = 1'b1;
        wait_neg(2);
        phi_l2 = 1'b0;
        wait_neg(8);
        chk("sample_ref_cycle", last_sref_cyc, 32'd104);
        chk("sample_sig_cycle", last_ssig_cyc, 32'd125);
        chk("timing_sref_count", cnt_sref, 32'd1);
        chk("timing_ssig_count", cnt_ssig, 32'd1);

        for (int p = 1; p < 4; p++) do_pixel(1, p, 0, 0);
        chk("line0_ls_count", cnt_ls, exp_ls);
        chk("line0_sref_count", cnt_sref, 32'd4);
        chk("line0_ssig_count", cnt_ssig, 32'd4);
        chk("line0_line_adv", {22'd0, line_idx}, 32'd1);

        exp_ls_line = 1;
        p_pulse();
        for (int p = 0; p < 4; p++) do_pixel(1, p, 1, (p == 3) ? 1 : 0);
        chk("frame1_fd_count", cnt_fd, 32'd1);
        chk("frame1_line_wrap", {22'd0, line_idx}, 32'd0);

        for (int l = 0; l < 2; l++) begin
            exp_ls_line = l;
            p_pulse();
            for (int p = 0; p < 4; p++) do_pixel(1, p, l, (p == 3 && l == 1) ? 1 : 0);
        end
        chk("frame2_fd_count", cnt_fd, exp_fd);
        chk("frame2_ssig_count", cnt_ssig, exp_ssig);
        chk("frame2_ls_count", cnt_ls, exp_ls);
        chk("frame2_line_wrap", {22'd0, line_idx}, 32'd0);
        chk("no_err_yet", {31'd0, err_short_line}, 32'd0);

        // short line: phi_p rises while the third pixel is in REF_CNT
        exp_ls_line = 0;
        p_pulse();
        do_pixel(1, 0, 0, 0);
        do_pixel(1, 1, 0, 0);
        exp_ls_line = 1;
        phi_r = 1'b1;
        wait_neg(2);
        phi_r = 1'b0;
        wait_neg(1);
        phi_p = 1'b1;
        wait_neg(2);
        phi_p = 1'b0;
        exp_ls++;
        wait_neg(8);
        chk("abort_err", {31'd0, err_short_line}, 32'd1);
        chk("abort_line_idx", {22'd0, line_idx}, 32'd1);
        chk("abort_pix_idx", {22'd0, pix_idx}, 32'd0);
        chk("abort_no_sref", cnt_sref, exp_sref);
        chk("abort_no_ssig", cnt_ssig, exp_ssig);
        chk("abort_ls_count", cnt_ls, exp_ls);
        for (int p = 0; p < 4; p++) do_pixel(1, p, 1, (p == 3) ? 1 : 0);
        chk("abort_frame_fd", cnt_fd, exp_fd);
        chk("abort_err_sticky", {31'd0, err_short_line}, 32'd1);

        // enable drop while counting to sample_ref
        exp_ls_line = 0;
        p_pulse();
        phi_r = 1'b1;
        wait_neg(2);
        phi_r = 1'b0;
        wait_neg(3);
        enable = 1'b0;
        wait_neg(8);
        chk("disable_no_sref", cnt_sref, exp_sref);
        chk("disable_err_kept", {31'd0, err_short_line}, 32'd1);
        chk("disable_pix_idx", {22'd0, pix_idx}, 32'd0);
        chk("disable_line_idx", {22'd0, line_idx}, 32'd0);
        enable = 1'b1;
        wait_neg(2);
        do_pixel(0, 0, 0, 0);
        chk("idle_needs_p_sref", cnt_sref, exp_sref);
        chk("idle_needs_p_ssig", cnt_ssig, exp_ssig);
        p_pulse();
        do_pixel(1, 0, 0, 0);
        do_pixel(1, 1, 0, 0);
        chk("reenable_ssig", cnt_ssig, exp_ssig);

        // reset while counting to sample_sig
        phi_r = 1'b1;
        wait_neg(2);
        phi_r = 1'b0;
        exp_sref++;
        wait_neg(3);
        phi_l1 = 1'b1;
        wait_neg(2);
        phi_l2 = 1'b1;
        wait_neg(3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("rst_mid_pixel_outputs");
        phi_l1 = 1'b0;
        phi_l2 = 1'b0;
        wait_neg(3);
        rst = 1'b0;
        wait_neg(15);
        chk("rst_no_ssig", cnt_ssig, exp_ssig);
        chk("rst_sref_count", cnt_sref, exp_sref);
        chk("rst_err_cleared", {31'd0, err_short_line}, 32'd0);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
